sprite_compositor: RTL and testbench

Parametrised VGA sprite renderer that replaces the fixed player/enemy/bullet drawing logic in the VGA wrapper. It sits between the VGA timing generator and the DAC. It composites NUM_SPRITES rectangular sprites plus a screen border into 8-bit RGB, with fixed priority. Sprite positions are double-buffered on a frame boundary, and pairwise sprite overlaps are reported once per frame.

---
 rtl/sprite_pkg.sv | 18 +
 rtl/sprite_hit.sv | 34 +++
 rtl/sprite_compositor.sv | 159 +++++++++++++++
 tb/tb_sprite_compositor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite compositor.
package sprite_pkg;

    typedef logic [2:0] rgb3_t;

    function automatic logic [23:0] rgb_expand(input rgb3_t c);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

    function automatic int pair_index(input int i, input int j, input int n);
        return i * (2 * n - i - 1) / 2 + (j - i - 1);
    endfunction

    function automatic int num_pairs(input int n);
        return n * (n - 1) / 2;
    endfunction

endpackage

// File: rtl/sprite_hit.sv
// Inclusive bounding-box test for one sprite against the current pixel.
module sprite_hit #(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int SPRITE_W = 10,
    parameter int SPRITE_H = 10
) (
    input  logic [9:0]     xCount,
    input  logic [9:0]     yCount,
    input  logic [X_W-1:0] sx,
    input  logic [Y_W-1:0] sy,
    input  logic           en,
    output logic           hit
);

    // One extra bit on the far edge so sprites clip instead of wrapping.
    localparam int XC = (X_W + 1 > 10) ? X_W + 1 : 10;
    localparam int YC = (Y_W + 1 > 10) ? Y_W + 1 : 10;

    logic [XC-1:0] xPos, xLo, xHi;
    logic [YC-1:0] yPos, yLo, yHi;

    assign xPos = XC'(xCount);
    assign xLo  = XC'(sx);
    assign xHi  = XC'(sx) + XC'(SPRITE_W - 1);
    assign yPos = YC'(yCount);
    assign yLo  = YC'(sy);
    assign yHi  = YC'(sy) + YC'(SPRITE_H - 1);

    assign hit = en
        && (xPos >= xLo) && (xPos <= xHi)
        && (yPos >= yLo) && (yPos <= yHi);

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite/border compositor with frame-boundary shadow registers.
// Define COLLISION_EN to build the per-pair collision accumulator.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int    NUM_SPRITES = 4,
    parameter int    X_W         = 10,
    parameter int    Y_W         = 9,
    parameter int    SPRITE_W    = 10,
    parameter int    SPRITE_H    = 10,
    parameter int    BORDER      = 11,
    parameter int    H_ACTIVE    = 640,
    parameter int    V_ACTIVE    = 480,
    parameter rgb3_t BORDER_RGB  = 3'b001
) (
    input  logic                             VGA_clk,
    input  logic                             reset,
    input  logic [9:0]                       xCount,
    input  logic [9:0]                       yCount,
    input  logic                             displayArea,
    input  logic                             hSync_in,
    input  logic                             vSync_in,
    input  logic [NUM_SPRITES*X_W-1:0]       sprite_x,
    input  logic [NUM_SPRITES*Y_W-1:0]       sprite_y,
    input  logic [NUM_SPRITES-1:0]           sprite_en,
    input  logic [NUM_SPRITES*3-1:0]         sprite_rgb,
    output logic [7:0]                       VGA_R,
    output logic [7:0]                       VGA_G,
    output logic [7:0]                       VGA_B,
    output logic                             VGA_hSync,
    output logic                             VGA_vSync,
    output logic [num_pairs(NUM_SPRITES)-1:0] collision_flags,
    output logic                             collision_valid
);

    localparam int NP = num_pairs(NUM_SPRITES);

    logic [NUM_SPRITES*X_W-1:0] shX;
    logic [NUM_SPRITES*Y_W-1:0] shY;
    logic [NUM_SPRITES-1:0]     shEn;
    logic [NUM_SPRITES*3-1:0]   shRgb;
    logic [NUM_SPRITES-1:0]     hit;
    logic                       frameBoundary;
    logic                       borderHit;

    assign frameBoundary = (xCount == '0) && (yCount == 10'(V_ACTIVE));

    assign borderHit = (xCount < 10'(BORDER))
        || (xCount >= 10'(H_ACTIVE - BORDER))
        || (yCount < 10'(BORDER))
        || (yCount >= 10'(V_ACTIVE - BORDER));

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            shX   <= '0;
            shY   <= '0;
            shEn  <= '0;
            shRgb <= '0;
        end else if (frameBoundary) begin
            shX   <= sprite_x;
            shY   <= sprite_y;
            shEn  <= sprite_en;
            shRgb <= sprite_rgb;
        end
    end

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
        sprite_hit #(
            .X_W     (X_W),
            .Y_W     (Y_W),
            .SPRITE_W(SPRITE_W),
            .SPRITE_H(SPRITE_H)
        ) u_hit (
            .xCount(xCount),
            .yCount(yCount),
            .sx    (shX[i*X_W +: X_W]),
            .sy    (shY[i*Y_W +: Y_W]),
            .en    (shEn[i]),
            .hit   (hit[i])
        );
    end

    logic [NUM_SPRITES-1:0] hitQ;
    logic                   borderQ;
    logic                   deQ;
    logic                   hsQ;
    logic                   vsQ;

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            hitQ    <= '0;
            borderQ <= 1'b0;
            deQ     <= 1'b0;
            hsQ     <= 1'b1;
            vsQ     <= 1'b1;
        end else begin
            hitQ    <= hit;
            borderQ <= borderHit;
            deQ     <= displayArea;
            hsQ     <= hSync_in;
            vsQ     <= vSync_in;
        end
    end

    rgb3_t pixRgb;

    // Walk from the highest index down so the lowest hitting sprite wins.
    always_comb begin
        pixRgb = '0;
        if (borderQ) pixRgb = BORDER_RGB;
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (hitQ[k]) pixRgb = shRgb[k*3 +: 3];
        end
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            {VGA_R, VGA_G, VGA_B} <= '0;
            VGA_hSync             <= 1'b1;
            VGA_vSync             <= 1'b1;
        end else begin
            {VGA_R, VGA_G, VGA_B} <= deQ ? rgb_expand(pixRgb) : 24'h0;
            VGA_hSync             <= hsQ;
            VGA_vSync             <= vsQ;
        end
    end

`ifdef COLLISION_EN
    logic [NP-1:0] pairHit;
    logic [NP-1:0] acc;

    for (genvar a = 0; a < NUM_SPRITES; a++) begin : g_pa
        for (genvar b = a + 1; b < NUM_SPRITES; b++) begin : g_pb
            localparam int P = pair_index(a, b, NUM_SPRITES);
            assign pairHit[P] = hit[a] & hit[b];
        end
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            acc             <= '0;
            collision_flags <= '0;
            collision_valid <= 1'b0;
        end else begin
            collision_valid <= frameBoundary;
            if (frameBoundary) begin
                collision_flags <= acc;
                acc             <= '0;
            end else if (displayArea) begin
                acc <= acc | pairHit;
            end
        end
    end
`else
    assign collision_flags = '0;
    assign collision_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor at default parameters.
module tb_sprite_compositor;

    logic        VGA_clk = 1'b0;
    logic        reset;
    logic [9:0]  xCount;
    logic [9:0]  yCount;
    logic        displayArea;
    logic        hSync_in;
    logic        vSync_in;
    logic [39:0] sprite_x;
    logic [35:0] sprite_y;
    logic [3:0]  sprite_en;
    logic [11:0] sprite_rgb;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_hSync, VGA_vSync;
    logic [5:0]  collision_flags;
    logic        collision_valid;

    int errors = 0;
    int checks = 0;

`ifdef COLLISION_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    sprite_compositor dut (
        .VGA_clk        (VGA_clk),
        .reset          (reset),
        .xCount         (xCount),
        .yCount         (yCount),
        .displayArea    (displayArea),
        .hSync_in       (hSync_in),
        .vSync_in       (vSync_in),
        .sprite_x       (sprite_x),
        .sprite_y       (sprite_y),
        .sprite_en      (sprite_en),
        .sprite_rgb     (sprite_rgb),
        .VGA_R          (VGA_R),
        .VGA_G          (VGA_G),
        .VGA_B          (VGA_B),
        .VGA_hSync      (VGA_hSync),
        .VGA_vSync      (VGA_vSync),
        .collision_flags(collision_flags),
        .collision_valid(collision_valid)
    );

    always #5 VGA_clk = ~VGA_clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge VGA_clk);
        #1;
    endtask

    // Hold one pixel long enough for it to reach the outputs.
    task automatic px(input int x, input int y);
        xCount      = 10'(x);
        yCount      = 10'(y);
        displayArea = 1'b1;
        tick();
        tick();
    endtask

    task automatic fb();
        xCount      = 10'd0;
        yCount      = 10'd480;
        displayArea = 1'b0;
        tick();
    endtask

    task automatic setSpr(input int i, input int x, input int y,
                          input logic [2:0] c, input logic en);
        sprite_x[i*10 +: 10] = 10'(x);
        sprite_y[i*9 +: 9]   = 9'(y);
        sprite_rgb[i*3 +: 3] = c;
        sprite_en[i]         = en;
    endtask

    function automatic logic [31:0] col();
        return {8'h0, VGA_R, VGA_G, VGA_B};
    endfunction

    initial begin
        reset       = 1'b1;
        xCount      = '0;
        yCount      = '0;
        displayArea = 1'b0;
        hSync_in    = 1'b1;
        vSync_in    = 1'b1;
        sprite_x    = '0;
        sprite_y    = '0;
        sprite_en   = '0;
        sprite_rgb  = '0;
        tick();
        tick();
        check("rst_rgb", col(), 32'h0);
        check("rst_hs", 32'(VGA_hSync), 32'h1);
        check("rst_vs", 32'(VGA_vSync), 32'h1);
        check("rst_flags", 32'(collision_flags), 32'h0);
        check("rst_valid", 32'(collision_valid), 32'h0);
        reset = 1'b0;

        px(5, 100);
        check("border_left", col(), 32'h0000FF);
        px(639, 240);
        check("border_right", col(), 32'h0000FF);
        px(629, 240);
        check("border_right_edge", col(), 32'h0000FF);
        px(628, 240);
        check("inside_right", col(), 32'h0);
        px(11, 240);
        check("inside_left", col(), 32'h0);
        px(320, 469);
        check("border_bottom", col(), 32'h0000FF);
        px(320, 468);
        check("inside_bottom", col(), 32'h0);
        px(320, 240);
        check("interior", col(), 32'h0);
        px(5, 100);
        displayArea = 1'b0;
        tick();
        tick();
        check("blank_black", col(), 32'h0);

        hSync_in = 1'b0;
        vSync_in = 1'b0;
        tick();
        check("hs_d1", 32'(VGA_hSync), 32'h1);
        hSync_in = 1'b1;
        vSync_in = 1'b1;
        tick();
        check("hs_d2", 32'(VGA_hSync), 32'h0);
        check("vs_d2", 32'(VGA_vSync), 32'h0);
        tick();
        check("hs_d3", 32'(VGA_hSync), 32'h1);

        setSpr(0, 100, 50, 3'b100, 1'b1);
        px(100, 50);
        check("pre_fb_shadow", col(), 32'h0);
        fb();
        check("fb1_valid", 32'(collision_valid), 32'(CE));
        px(100, 50);
        check("s0_tl", col(), 32'hFF0000);
        px(109, 59);
        check("s0_br", col(), 32'hFF0000);
        px(99, 50);
        check("s0_left_out", col(), 32'h0);
        px(110, 50);
        check("s0_right_out", col(), 32'h0);
        px(100, 60);
        check("s0_below_out", col(), 32'h0);

        setSpr(0, 105, 55, 3'b100, 1'b1);
        setSpr(1, 100, 50, 3'b010, 1'b1);
        fb();
        check("fb2_flags", 32'(collision_flags), 32'h0);
        px(107, 57);
        check("overlap_prio", col(), 32'hFF0000);
        px(101, 51);
        check("s1_only", col(), 32'h00FF00);

        setSpr(0, 200, 50, 3'b100, 1'b1);
        fb();
        check("fb3_valid", 32'(collision_valid), 32'(CE));
        check("fb3_flags", 32'(collision_flags), CE ? 32'h1 : 32'h0);
        px(200, 50);
        check("valid_drop", 32'(collision_valid), 32'h0);
        check("sep_s0", col(), 32'hFF0000);
        px(105, 55);
        check("sep_s1", col(), 32'h00FF00);
        fb();
        check("fb4_flags", 32'(collision_flags), 32'h0);

        setSpr(0, 300, 50, 3'b100, 1'b1);
        px(200, 50);
        check("tear_old", col(), 32'hFF0000);
        px(300, 50);
        check("tear_new_pre", col(), 32'h0);
        fb();
        px(300, 50);
        check("tear_new_post", col(), 32'hFF0000);
        px(200, 50);
        check("tear_old_post", col(), 32'h0);

        setSpr(0, 635, 50, 3'b100, 1'b1);
        setSpr(1, 100, 50, 3'b010, 1'b0);
        fb();
        px(639, 55);
        check("clip_639", col(), 32'hFF0000);
        px(635, 55);
        check("clip_635", col(), 32'hFF0000);
        px(634, 55);
        check("clip_634", col(), 32'h0000FF);
        px(0, 55);
        check("no_wrap_0", col(), 32'h0000FF);

        setSpr(1, 636, 50, 3'b010, 1'b1);
        fb();
        px(637, 52);
        check("pre_rst_pix", col(), 32'hFF0000);
        fb();
        check("fb_pre_rst", 32'(collision_flags), CE ? 32'h1 : 32'h0);
        px(637, 52);
        reset = 1'b1;
        tick();
        check("mid_rst_rgb", col(), 32'h0);
        check("mid_rst_flags", 32'(collision_flags), 32'h0);
        check("mid_rst_valid", 32'(collision_valid), 32'h0);
        reset = 1'b0;
        px(637, 52);
        check("post_rst_border", col(), 32'h0000FF);
        fb();
        check("post_rst_flags", 32'(collision_flags), 32'h0);
        check("post_rst_valid", 32'(collision_valid), 32'(CE));
        px(637, 52);
        check("post_fb_sprite", col(), 32'hFF0000);
        px(0, 52);
        check("post_fb_no_wrap", col(), 32'h0000FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
